// File: rtl/layer_serializer.sv
// -----------------------------------------------------------------------------
// layer_serializer
//
// Turns one packed layer output (neuron_number elements of dataWidth bits) into
// a stream of single elements for the next layer. Two frame buffers are kept:
// an active shift buffer that is being streamed, and a single-entry hold buffer
// that absorbs the next frame so consecutive frames stream without a bubble.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     packed frame on in_data is valid
//   in_data      packed frame, element k at [dataWidth*k +: dataWidth]
//   in_ready     a frame can be accepted (hold buffer empty)
//   out_ready    downstream can take one element this cycle
//   out_valid    out_data holds a valid element
//   out_data     current element (registered)
//   out_index    index of the current element (registered)
//   out_last     current element is the last of its frame
//   freeze_next  low only on cycles where an element is transferred
// -----------------------------------------------------------------------------
module layer_serializer #(
    parameter int neuron_number = 10,
    parameter int dataWidth     = 16,
    parameter int idxWidth      = $clog2(neuron_number)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [neuron_number*dataWidth-1:0] in_data,
    output logic                               in_ready,
    input  logic                               out_ready,
    output logic                               out_valid,
    output logic [dataWidth-1:0]               out_data,
    output logic [idxWidth-1:0]                out_index,
    output logic                               out_last,
    output logic                               freeze_next
);

    localparam int FRAME_W = neuron_number * dataWidth;
    // The active buffer only keeps the elements after the one on out_data.
    localparam int REST_W  = (neuron_number - 1) * dataWidth;

    localparam logic [idxWidth-1:0] LAST_IDX = idxWidth'(neuron_number - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]           state_q,     state_d;
    logic                 out_valid_q, out_valid_d;
    logic [dataWidth-1:0] out_data_q,  out_data_d;
    logic [idxWidth-1:0]  out_index_q, out_index_d;
    logic                 hold_full_q, hold_full_d;
    logic [REST_W-1:0]    active_q,    active_d;
    logic [FRAME_W-1:0]   hold_q,      hold_d;

    logic                 in_xfer;
    logic                 out_xfer;
    logic                 last_w;
    logic                 load_en;
    logic [FRAME_W-1:0]   load_frame;

    // -------------------------------------------------------------------------
    // Handshakes and decoded outputs
    // -------------------------------------------------------------------------
    // in_ready depends on state only, so upstream never sees a combinational
    // path from out_ready or in_valid.
    assign in_ready    = ~hold_full_q;
    assign in_xfer     = in_valid & in_ready;
    assign out_xfer    = out_valid_q & out_ready;
    assign last_w      = out_valid_q & (out_index_q == LAST_IDX);

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_index   = out_index_q;
    assign out_last    = last_w;
    assign freeze_next = ~out_xfer;

    // A new active frame comes from the hold buffer when it is occupied,
    // otherwise straight from the input port.
    assign load_frame  = hold_full_q ? hold_q : in_data;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default here so no path through the case
        // leaves it unassigned; that is what keeps this block free of latches.
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        hold_full_d = hold_full_q;
        active_d    = active_q;
        hold_d      = hold_q;
        load_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Hold is always empty here, so load_frame is in_data.
                if (in_xfer) begin
                    load_en = 1'b1;
                end
            end

            ST_STREAM: begin
                if (out_xfer) begin
                    if (!last_w) begin
                        // Step to the next element of the same frame.
                        out_index_d = out_index_q + 1'b1;
                        out_data_d  = active_q[dataWidth-1:0];
                        active_d    = active_q >> dataWidth;
                    end else if (hold_full_q || in_xfer) begin
                        // Frame boundary with a successor ready: restart at
                        // element 0 on the next cycle, no bubble.
                        load_en     = 1'b1;
                        hold_full_d = 1'b0;
                    end else begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end
                end

                // A frame accepted while streaming parks in the hold buffer,
                // unless it was consumed directly at the frame boundary above.
                // in_xfer implies hold is empty, so it never collides with a
                // hold-to-active move.
                if (in_xfer && !(out_xfer && last_w)) begin
                    hold_d      = in_data;
                    hold_full_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                hold_full_d = 1'b0;
            end
        endcase

        if (load_en) begin
            state_d     = ST_STREAM;
            out_valid_d = 1'b1;
            out_index_d = '0;
            out_data_d  = load_frame[dataWidth-1:0];
            active_d    = load_frame[FRAME_W-1:dataWidth];
        end
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            hold_full_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the same pre-edge values of its neighbours.
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            hold_full_q <= hold_full_d;
        end
    end

    // -------------------------------------------------------------------------
    // Frame buffers
    // -------------------------------------------------------------------------
    // NOTE: the buffers carry no reset. Their contents are only ever observed
    // after a load, and the reset of state_q/hold_full_q already discards
    // whatever they held, so resetting the wide data would only cost routing.
    always_ff @(posedge clk) begin
        active_q <= active_d;
        hold_q   <= hold_d;
    end

endmodule
